// File: rtl/div_sched.sv
// div_sched: round-robin front end for a shared pipelined divider.
// Requesters compete for one issue slot per cycle. Each result goes into a
// small result FIFO together with its requester id and a zero-divisor flag.
// Credit-based flow control means the FIFO can never overflow.
module div_sched #(
    parameter int BITS       = 48,
    parameter int DIV_LAT    = 48,
    parameter int NREQ       = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*2*BITS-1:0]     req_x,
    input  logic [NREQ*BITS-1:0]       req_y,
    output logic [2*BITS-1:0]          div_x,
    output logic [BITS-1:0]            div_y,
    input  logic [BITS-1:0]            div_z,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [BITS-1:0]            res_data,
    output logic [$clog2(NREQ)-1:0]    res_id,
    output logic                       res_dz,
    output logic                       busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int XW  = 2 * BITS;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_S = (CW + 1)'(FIFO_DEPTH);

    // Per-requester operand views
    logic [XW-1:0]   x_arr [NREQ];
    logic [BITS-1:0] y_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign x_arr[gi] = req_x[gi*XW +: XW];
        assign y_arr[gi] = req_y[gi*BITS +: BITS];
    end

    // Scheduler and counter state
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [XW-1:0]  div_x_q;
    logic [BITS-1:0] div_y_q;

    // Tag pipeline: stage k holds the tag for an operand issued k+1 edges ago
    logic [DIV_LAT:0] tag_v_q;
    logic [DIV_LAT:0] tag_dz_q;
    logic [IDW-1:0]   tag_id_q [DIV_LAT+1];

    // Result FIFO storage (small, so read asynchronously from distributed RAM)
    logic [BITS-1:0] mem_data [FIFO_DEPTH];
    logic [IDW-1:0]  mem_id   [FIFO_DEPTH];
    logic            mem_dz   [FIFO_DEPTH];

    logic           credit_ok, grant_found, issue, push, pop, grant_dz;
    logic [IDW-1:0] grant_id, cand;

    // Credit counts every result that still needs a FIFO slot; uses registered counts only
    assign credit_ok = ({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_S;
    assign push      = tag_v_q[DIV_LAT];
    assign res_valid = !rst && (count_q != '0);
    assign pop       = res_valid && res_ready;
    assign busy      = !rst && ((inflight_q != '0) || (count_q != '0));
    assign grant_dz  = (y_arr[grant_id] == '0);
    assign div_x     = div_x_q;
    assign div_y     = div_y_q;
    assign res_data  = mem_data[rd_ptr_q];
    assign res_id    = mem_id[rd_ptr_q];
    assign res_dz    = mem_dz[rd_ptr_q];

    // Round-robin search from ptr_q, wrapping naturally in IDW bits
    always_comb begin
        grant_found = 1'b0;
        grant_id    = ptr_q;
        cand        = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr_q + IDW'(k);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
        issue     = !rst && credit_ok && grant_found;
        req_ready = '0;
        if (issue) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Next-state for pointer, in-flight count and FIFO bookkeeping
    always_comb begin
        ptr_d      = ptr_q;
        inflight_d = inflight_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (issue) begin
            ptr_d = grant_id + IDW'(1);
        end
        case ({issue, push})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    // Control registers and divider operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            div_x_q    <= '0;
            div_y_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (issue) begin
                div_x_q <= x_arr[grant_id];
                div_y_q <= y_arr[grant_id];
            end
        end
    end

    // Tag shift register; only the valid bits need clearing on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v_q <= '0;
        end else begin
            tag_v_q <= {tag_v_q[DIV_LAT-1:0], issue};
        end
        tag_dz_q    <= {tag_dz_q[DIV_LAT-1:0], grant_dz};
        tag_id_q[0] <= grant_id;
        for (int k = 1; k <= DIV_LAT; k++) begin
            tag_id_q[k] <= tag_id_q[k-1];
        end
    end

    // FIFO write port: capture the divider output as its tag leaves the pipeline
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_data[wr_ptr_q] <= div_z;
            mem_id[wr_ptr_q]   <= tag_id_q[DIV_LAT];
            mem_dz[wr_ptr_q]   <= tag_dz_q[DIV_LAT];
        end
    end

    // A push into a full FIFO means the credit accounting is broken
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == DEPTH_C)));

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter BITS, default 48, divisor/quotient width; dividend width is 2*BITS.
REQ-002 Parameter DIV_LAT, default 48, edges from div_x/div_y change to matching div_z valid.
REQ-003 Parameter NREQ, default 4, number of requesters (power of 2, >=2).
REQ-004 Parameter FIFO_DEPTH, default 8, result FIFO entries (power of 2, >=2).
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  NREQ  per-requester operand valid.
REQ-008 req_ready  out  NREQ  per-requester grant; one-hot or zero.
REQ-009 req_x  in  NREQ*2*BITS  packed signed dividends, requester i at slice i.
REQ-010 req_y  in  NREQ*BITS  packed signed divisors, requester i at slice i.
REQ-011 div_x  out  2*BITS  registered dividend to the shared pipelined divider.
REQ-012 div_y  out  BITS  registered divisor to the shared pipelined divider.
REQ-013 div_z  in  BITS  signed quotient from the divider.
REQ-014 res_valid  out  1  FIFO head valid.
REQ-015 res_ready  in  1  consumer accepts head.
REQ-016 res_data  out  BITS  quotient at FIFO head.
REQ-017 res_id  out  log2(NREQ)  originating requester of head.
REQ-018 res_dz  out  1  head's divisor was zero (res_data then meaningless).
REQ-019 busy  out  1  high while any issue is in flight or FIFO non-empty.

Function
REQ-020 Issue transfer for requester i occurs on an edge where req_valid[i] and req_ready[i] are both high; at most one issue per cycle.
REQ-021 req_ready is combinational: asserted only for the round-robin winner, and only when credit_ok = (fifo_count + inflight < FIFO_DEPTH), using registered counts.
REQ-022 Round-robin: search starts at pointer ptr and wraps modulo NREQ; after an issue to i, ptr <= (i+1) mod NREQ; without an issue ptr holds.
REQ-023 On issue, div_x/div_y load the winner's operands; without an issue they hold their last values.
REQ-024 A tag pipeline of DIV_LAT+1 stages carries {valid, id, dz}; stage 0 loads on issue (valid=0 otherwise); dz = (req_y slice == 0).
REQ-025 When the last tag stage is valid, div_z is written to the FIFO tail with that id and dz on the same edge; total issue-to-FIFO-write latency is DIV_LAT+1 edges.
REQ-026 Back-to-back issue every cycle is supported; results retire in issue order, one per cycle.
REQ-027 inflight increments on issue, decrements on retire, unchanged when both occur in the same cycle.
REQ-028 FIFO pop occurs on an edge with res_valid and res_ready high; a pop does not free credit until the following cycle.
REQ-029 Simultaneous push and pop leaves fifo_count unchanged, including at fifo_count = FIFO_DEPTH-1 and with fifo_count = 1.
REQ-030 The credit rule guarantees no FIFO overflow; a push when full is a design error and is flagged by an assertion.
REQ-031 FIFO pointers wrap modulo FIFO_DEPTH; res_data/res_id/res_dz are stable while res_valid is high and res_ready is low.
REQ-032 The controller does not inspect operand signs or values other than the zero-divisor check.

Reset
REQ-033 While rst is high: req_ready=0, res_valid=0, busy=0, ptr=0, inflight=0, fifo_count=0, all tag valids=0, div_x=0, div_y=0.
REQ-034 rst asserted mid-operation discards all in-flight tags and FIFO contents; div_z arriving afterwards is ignored.
REQ-035 First grant after rst deassertion may occur in the first cycle with rst low.

Verification
REQ-036 Single issue: requester 2 sends x=100, y=7, res_ready=1 -> res_valid exactly DIV_LAT+1 cycles later, res_data=14, res_id=2, res_dz=0.
REQ-037 Fairness: all NREQ=4 req_valid held high, res_ready=1 -> grant order 0,1,2,3,0,... one per cycle; results return in that order.
REQ-038 Backpressure: res_ready=0, continuous requests -> exactly FIFO_DEPTH=8 issues, then req_ready=0 until res_ready rises; no result lost or duplicated.
REQ-039 Zero divisor: x=-50, y=0 from requester 1 -> res_dz=1, res_id=1; next request x=-50, y=5 -> res_data=-10, res_dz=0.
REQ-040 Reset mid-flight: issue 3 requests, assert rst for 1 cycle at cycle 5 -> no res_valid ever for those 3, busy=0 after reset, next issue completes normally.
REQ-041 Simultaneous push/pop at fifo_count=7 with inflight=1 -> count stays 7, no overflow assertion.
